rezultat_bcd: RTL

Result formatter that sits directly downstream of the arithmetic units (suma, diferenta, produs, impartire). It accepts one 28-bit signed result plus that unit's error flag. It converts the magnitude to 8 packed BCD digits with a separate sign bit, using an iterative shift-add-3 (double dabble) engine. The output feeds the display driver; a value outside ±99,999,999 or a flagged upstream error is reported as err_out.

---
 rtl/rezultat_bcd.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/rezultat_bcd.sv
// Signed binary result to sign + packed BCD converter for the display path.
// Uses a fixed-length shift-add-3 (double dabble) loop, one bit per cycle.
module rezultat_bcd #(
   parameter int WIDTH  = 28,
   parameter int DIGITS = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  valid_in,
   input  logic [WIDTH-1:0]      d_in,
   input  logic                  err_in,
   output logic                  ready,
   output logic                  valid_out,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  neg,
   output logic                  err_out
);

   localparam int SW = 4*DIGITS + 4;
   localparam int BW = 4*DIGITS;
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   function automatic logic [63:0] maxValue();
      logic [63:0] v;
      v = 64'd1;
      for (int i = 0; i < DIGITS; i++) begin
         v = v * 64'd10;
      end
      return v - 64'd1;
   endfunction

   localparam logic [63:0] MAX_VAL = maxValue();

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_e;

   state_e            state_q, state_d;
   logic [SW-1:0]     scratch_q, scratch_d;
   logic [WIDTH-1:0]  mag_q, mag_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              sign_q, sign_d;
   logic              errFlag_q, errFlag_d;
   logic [BW-1:0]     bcd_q, bcd_d;
   logic              neg_q, neg_d;
   logic              errOut_q, errOut_d;
   logic              validOut_q, validOut_d;

   logic [WIDTH-1:0]  magAbs;
   logic              rangeErr;
   logic [SW-1:0]     adjusted;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (valid_in) state_d = SHIFT;
         SHIFT:   if (cnt_q == LAST_CNT) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ready = (state_q == IDLE);
   end

   // Two's-complement magnitude: the most negative value maps to 2^(WIDTH-1), which still fits unsigned.
   always_comb begin
      magAbs   = d_in[WIDTH-1] ? (-d_in) : d_in;
      rangeErr = (64'(magAbs) > MAX_VAL);
   end

   always_comb begin
      adjusted = '0;
      for (int i = 0; i < DIGITS + 1; i++) begin
         if (scratch_q[4*i +: 4] >= 4'd5) begin
            adjusted[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
         end else begin
            adjusted[4*i +: 4] = scratch_q[4*i +: 4];
         end
      end
   end

   always_comb begin
      scratch_d  = scratch_q;
      mag_d      = mag_q;
      cnt_d      = cnt_q;
      sign_d     = sign_q;
      errFlag_d  = errFlag_q;
      bcd_d      = bcd_q;
      neg_d      = neg_q;
      errOut_d   = errOut_q;
      validOut_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (valid_in) begin
               sign_d    = d_in[WIDTH-1];
               mag_d     = magAbs;
               errFlag_d = err_in | rangeErr;
               scratch_d = '0;
               cnt_d     = '0;
            end
         end
         SHIFT: begin
            scratch_d = {adjusted[SW-2:0], mag_q[WIDTH-1]};
            mag_d     = {mag_q[WIDTH-2:0], 1'b0};
            cnt_d     = cnt_q + 1'b1;
         end
         DONE: begin
            // Errors blank the digits and sign so the display never shows a bogus partial value.
            if (errFlag_q) begin
               bcd_d = '0;
               neg_d = 1'b0;
            end else begin
               bcd_d = scratch_q[BW-1:0];
               neg_d = sign_q;
            end
            errOut_d   = errFlag_q;
            validOut_d = 1'b1;
         end
         default: begin
            validOut_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scratch_q  <= '0;
         mag_q      <= '0;
         cnt_q      <= '0;
         sign_q     <= 1'b0;
         errFlag_q  <= 1'b0;
         bcd_q      <= '0;
         neg_q      <= 1'b0;
         errOut_q   <= 1'b0;
         validOut_q <= 1'b0;
      end else begin
         scratch_q  <= scratch_d;
         mag_q      <= mag_d;
         cnt_q      <= cnt_d;
         sign_q     <= sign_d;
         errFlag_q  <= errFlag_d;
         bcd_q      <= bcd_d;
         neg_q      <= neg_d;
         errOut_q   <= errOut_d;
         validOut_q <= validOut_d;
      end
   end

   assign valid_out = validOut_q;
   assign bcd       = bcd_q;
   assign neg       = neg_q;
   assign err_out   = errOut_q;

endmodule
